// File: rtl/tone_arbiter.sv
// tone_arbiter: fixed-priority owner of the single square-wave tone generator.
// Grants one of three note requesters, times the note in ms derived from
// ticks_per_milli, inserts a silent gap after each completed note and, when
// PREEMPT is set, lets a higher-priority requester abort the current note.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | generator silent, any requester may be granted
// ST_PLAY | note (or timed rest) running, only higher priority may preempt
// ST_GAP  | silent gap after a completed note, no grants
module tone_arbiter #(
   parameter int GAP_MS  = 20,
   parameter int PREEMPT = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] ticks_per_milli,
   input  logic [2:0]  req_valid,
   input  logic [29:0] req_freq,
   input  logic [29:0] req_ms,
   output logic [2:0]  req_ready,
   output logic [9:0]  freq,
   output logic [2:0]  note_done,
   output logic [2:0]  note_aborted,
   output logic [1:0]  active,
   output logic        busy
);

   localparam logic [9:0] GAP_LEN  = 10'(GAP_MS);
   localparam logic [1:0] NO_OWNER = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_PLAY,
      ST_GAP
   } state_t;

   state_t      state, state_nxt;
   logic [9:0]  freq_nxt;
   logic [1:0]  active_nxt;
   logic [2:0]  done_nxt, abort_nxt;
   logic [9:0]  lat_ms, lat_ms_nxt;
   logic [15:0] t_lat, t_lat_nxt;
   logic [15:0] tick_cnt, tick_nxt;
   logic [9:0]  ms_cnt, ms_nxt;

   logic [2:0]  eligible;
   logic [1:0]  acc_idx;
   logic [9:0]  acc_freq, acc_ms;
   logic [15:0] acc_t;
   logic        accept;
   logic        tick_wrap;
   logic [2:0]  owner_onehot;

   // Grant: lowest eligible index. A requester whose done pulse is visible
   // this cycle is masked so done and a new accept never coincide for it.
   always_comb begin
      eligible = 3'b000;
      case (state)
         ST_IDLE: eligible = req_valid & ~note_done;
         ST_PLAY: begin
            if (PREEMPT != 0) begin
               case (active)
                  2'd1:    eligible = req_valid & 3'b001;
                  2'd2:    eligible = req_valid & 3'b011;
                  default: eligible = 3'b000;
               endcase
            end
         end
         default: eligible = 3'b000;
      endcase
      req_ready = 3'b000;
      if (eligible[0])      req_ready = 3'b001;
      else if (eligible[1]) req_ready = 3'b010;
      else if (eligible[2]) req_ready = 3'b100;
   end

   // Select the fields of the granted requester and derive per-note timing.
   always_comb begin
      acc_idx = 2'd0;
      if (req_ready[1])      acc_idx = 2'd1;
      else if (req_ready[2]) acc_idx = 2'd2;
      case (acc_idx)
         2'd1: begin
            acc_freq = req_freq[19:10];
            acc_ms   = req_ms[19:10];
         end
         2'd2: begin
            acc_freq = req_freq[29:20];
            acc_ms   = req_ms[29:20];
         end
         default: begin
            acc_freq = req_freq[9:0];
            acc_ms   = req_ms[9:0];
         end
      endcase
      accept       = |req_ready;
      acc_t        = (ticks_per_milli == 16'd0) ? 16'd1 : ticks_per_milli;
      tick_wrap    = (tick_cnt == t_lat - 16'd1);
      owner_onehot = 3'b001 << active;
   end

   // Next-state and next-output logic for the sequencer.
   always_comb begin
      state_nxt  = state;
      freq_nxt   = freq;
      active_nxt = active;
      done_nxt   = 3'b000;
      abort_nxt  = 3'b000;
      lat_ms_nxt = lat_ms;
      t_lat_nxt  = t_lat;
      tick_nxt   = tick_cnt;
      ms_nxt     = ms_cnt;
      case (state)
         ST_IDLE: begin
            freq_nxt   = 10'd0;
            active_nxt = NO_OWNER;
            if (accept) begin
               lat_ms_nxt = acc_ms;
               t_lat_nxt  = acc_t;
               tick_nxt   = 16'd0;
               ms_nxt     = 10'd0;
               if (acc_ms != 10'd0) begin
                  state_nxt  = ST_PLAY;
                  freq_nxt   = acc_freq;
                  active_nxt = acc_idx;
               end else begin
                  done_nxt = req_ready;
               end
            end
         end
         ST_PLAY: begin
            if (accept) begin
               abort_nxt  = owner_onehot;
               lat_ms_nxt = acc_ms;
               t_lat_nxt  = acc_t;
               tick_nxt   = 16'd0;
               ms_nxt     = 10'd0;
               if (acc_ms != 10'd0) begin
                  freq_nxt   = acc_freq;
                  active_nxt = acc_idx;
               end else begin
                  freq_nxt   = 10'd0;
                  active_nxt = NO_OWNER;
                  done_nxt   = req_ready;
                  state_nxt  = ST_IDLE;
               end
            end else if (tick_wrap) begin
               tick_nxt = 16'd0;
               if (ms_cnt + 10'd1 == lat_ms) begin
                  freq_nxt   = 10'd0;
                  done_nxt   = owner_onehot;
                  active_nxt = NO_OWNER;
                  ms_nxt     = 10'd0;
                  state_nxt  = (GAP_MS == 0) ? ST_IDLE : ST_GAP;
               end else begin
                  ms_nxt = ms_cnt + 10'd1;
               end
            end else begin
               tick_nxt = tick_cnt + 16'd1;
            end
         end
         ST_GAP: begin
            freq_nxt = 10'd0;
            if (tick_wrap) begin
               tick_nxt = 16'd0;
               if (ms_cnt + 10'd1 == GAP_LEN) begin
                  ms_nxt    = 10'd0;
                  state_nxt = ST_IDLE;
               end else begin
                  ms_nxt = ms_cnt + 10'd1;
               end
            end else begin
               tick_nxt = tick_cnt + 16'd1;
            end
         end
         default: begin
            state_nxt  = ST_IDLE;
            freq_nxt   = 10'd0;
            active_nxt = NO_OWNER;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   // Output, latch and counter registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         freq         <= 10'd0;
         active       <= NO_OWNER;
         note_done    <= 3'b000;
         note_aborted <= 3'b000;
         lat_ms       <= 10'd0;
         t_lat        <= 16'd1;
         tick_cnt     <= 16'd0;
         ms_cnt       <= 10'd0;
      end else begin
         freq         <= freq_nxt;
         active       <= active_nxt;
         note_done    <= done_nxt;
         note_aborted <= abort_nxt;
         lat_ms       <= lat_ms_nxt;
         t_lat        <= t_lat_nxt;
         tick_cnt     <= tick_nxt;
         ms_cnt       <= ms_nxt;
      end
   end

   assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_tone_arbiter.sv
// Bench for tone_arbiter: grant table, directed note sequences on a preempting
// and a non-preempting instance, then random traffic against a note-level model.
module tb_tone_arbiter;

   localparam int GAP = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] tpm;
   logic [2:0]  valid1, valid0;
   logic [29:0] rfreq, rms;

   logic [2:0]  ready1, done1, ab1, ready0, done0, ab0;
   logic [9:0]  freq1, freq0;
   logic [1:0]  active1, active0;
   logic        busy1, busy0;

   always #5 clk = ~clk;

   tone_arbiter #(.GAP_MS(GAP), .PREEMPT(1)) dut1 (
      .clk(clk), .rst(rst), .ticks_per_milli(tpm), .req_valid(valid1),
      .req_freq(rfreq), .req_ms(rms), .req_ready(ready1), .freq(freq1),
      .note_done(done1), .note_aborted(ab1), .active(active1), .busy(busy1)
   );

   tone_arbiter #(.GAP_MS(GAP), .PREEMPT(0)) dut0 (
      .clk(clk), .rst(rst), .ticks_per_milli(tpm), .req_valid(valid0),
      .req_freq(rfreq), .req_ms(rms), .req_ready(ready0), .freq(freq0),
      .note_done(done0), .note_aborted(ab0), .active(active0), .busy(busy0)
   );

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic [9:0] f, input logic [9:0] m);
      rfreq[i*10 +: 10] = f;
      rms[i*10 +: 10]   = m;
   endtask

   typedef struct {
      logic [2:0] valid;
      logic [2:0] ready;
   } vec_t;

   // Note-level reference: remaining tone / gap cycles instead of ms counters.
   int         m_own, m_freq, m_play, m_gap, m_t;
   logic [2:0] m_done, m_ab, m_ready;

   function automatic logic [2:0] lowest(input logic [2:0] v);
      logic [2:0] r;
      r = 3'b000;
      for (int i = 2; i >= 0; i--) if (v[i]) r = 3'(1 << i);
      return r;
   endfunction

   task automatic model_ready();
      logic [2:0] elig;
      elig = 3'b000;
      if (m_play == 0 && m_gap == 0) elig = valid1 & ~m_done;
      else if (m_play > 0)
         for (int i = 0; i < 3; i++) if (i < m_own) elig[i] = valid1[i];
      m_ready = lowest(elig);
   endtask

   task automatic model_step();
      int k, t, n;
      m_done = 3'b000;
      m_ab   = 3'b000;
      if (m_ready != 3'b000) begin
         k = m_ready[0] ? 0 : (m_ready[1] ? 1 : 2);
         t = (tpm == 16'd0) ? 1 : int'(tpm);
         n = int'(rms[k*10 +: 10]) * t;
         if (m_play > 0) m_ab[m_own] = 1'b1;
         m_gap = 0;
         if (n == 0) begin
            m_done[k] = 1'b1;
            m_own = -1; m_freq = 0; m_play = 0;
         end else begin
            m_own = k; m_freq = int'(rfreq[k*10 +: 10]); m_play = n; m_t = t;
         end
      end else if (m_play > 0) begin
         m_play--;
         if (m_play == 0) begin
            m_done[m_own] = 1'b1;
            m_own = -1; m_freq = 0; m_gap = GAP * m_t;
         end
      end else if (m_gap > 0) begin
         m_gap--;
      end
   endtask

   initial begin
      vec_t vecs[8];
      vecs[0] = '{3'b000, 3'b000};
      vecs[1] = '{3'b001, 3'b001};
      vecs[2] = '{3'b010, 3'b010};
      vecs[3] = '{3'b011, 3'b001};
      vecs[4] = '{3'b100, 3'b100};
      vecs[5] = '{3'b101, 3'b001};
      vecs[6] = '{3'b110, 3'b010};
      vecs[7] = '{3'b111, 3'b001};

      rst = 1'b1; tpm = 16'd4; valid1 = 3'b000; valid0 = 3'b000;
      rfreq = '0; rms = '0;
      tick(); tick();
      chk("rst_freq", freq1, 0);
      chk("rst_ready", ready1, 0);
      chk("rst_done", done1, 0);
      chk("rst_aborted", ab1, 0);
      chk("rst_active", active1, 3);
      chk("rst_busy", busy1, 0);
      rst = 1'b0;
      tick();

      // Grant table, applied between edges so nothing is accepted.
      for (int v = 0; v < 8; v++) begin
         valid1 = vecs[v].valid; valid0 = vecs[v].valid;
         #2;
         chk("table_ready_p1", ready1, vecs[v].ready);
         chk("table_ready_p0", ready0, vecs[v].ready);
         valid1 = 3'b000; valid0 = 3'b000;
         tick();
      end

      // Single note: r1 262 Hz, 3 ms.
      set_req(1, 262, 3); valid1 = 3'b010;
      #1 chk("single_ready", ready1, 3'b010);
      tick(); valid1 = 3'b000;
      chk("single_active", active1, 1);
      chk("single_busy", busy1, 1);
      for (int c = 0; c < 12; c++) begin
         chk("single_freq", freq1, 262);
         chk("single_no_done", done1, 0);
         tick();
      end
      chk("single_end_freq", freq1, 0);
      chk("single_done", done1, 3'b010);
      chk("single_end_active", active1, 3);
      for (int c = 0; c < 8; c++) begin
         chk("single_gap_busy", busy1, 1);
         chk("single_gap_freq", freq1, 0);
         if (c == 1) chk("single_done_pulse", done1, 0);
         tick();
      end
      chk("single_idle_busy", busy1, 0);
      chk("single_idle_active", active1, 3);

      // Priority: r0 and r2 together.
      set_req(0, 196, 2); set_req(2, 784, 2); valid1 = 3'b101;
      #1 chk("prio_ready", ready1, 3'b001);
      tick(); valid1 = 3'b100;
      for (int c = 0; c < 8; c++) begin
         chk("prio_freq_r0", freq1, 196);
         chk("prio_ready_play", ready1, 0);
         tick();
      end
      chk("prio_done_r0", done1, 3'b001);
      for (int c = 0; c < 8; c++) begin
         chk("prio_gap_ready", ready1, 0);
         chk("prio_gap_freq", freq1, 0);
         tick();
      end
      chk("prio_ready_r2", ready1, 3'b100);
      tick(); valid1 = 3'b000;
      chk("prio_active_r2", active1, 2);
      for (int c = 0; c < 8; c++) begin
         chk("prio_freq_r2", freq1, 784);
         tick();
      end
      chk("prio_done_r2", done1, 3'b100);
      for (int c = 0; c < 8; c++) tick();

      // Preemption on dut1, run-to-completion on dut0, same stimulus.
      set_req(2, 784, 10); valid1 = 3'b100; valid0 = 3'b100;
      #1 chk("pre_ready_p1", ready1, 3'b100);
      chk("pre_ready_p0", ready0, 3'b100);
      tick(); valid1 = 3'b000; valid0 = 3'b000;
      for (int p = 1; p <= 54; p++) begin
         if (p == 12) begin
            set_req(0, 196, 1); valid1 = 3'b001; valid0 = 3'b001;
            #1 chk("pre_ready_r0", ready1, 3'b001);
            chk("nopre_ready_r0", ready0, 3'b000);
         end
         if (p == 13) begin
            valid1 = 3'b000;
            chk("pre_aborted", ab1, 3'b100);
            chk("pre_active", active1, 0);
         end else begin
            chk("pre_no_abort", ab1, 0);
         end
         chk("pre_freq", freq1, (p <= 12) ? 784 : ((p <= 16) ? 196 : 0));
         chk("pre_no_done_r2", done1[2], 0);
         if (p == 17) chk("pre_done_r0", done1, 3'b001);
         chk("nopre_freq", freq0,
             (p <= 40) ? 784 : ((p >= 50 && p <= 53) ? 196 : 0));
         chk("nopre_no_abort", ab0, 0);
         if (p == 41) chk("nopre_done_r2", done0, 3'b100);
         if (p == 49) chk("nopre_ready_after_gap", ready0, 3'b001);
         if (p == 50) begin
            valid0 = 3'b000;
            chk("nopre_active_r0", active0, 0);
         end
         if (p == 54) chk("nopre_done_r0", done0, 3'b001);
         tick();
      end

      // Zero-length note.
      set_req(1, 300, 0); valid1 = 3'b010;
      #1 chk("zero_ready", ready1, 3'b010);
      tick(); valid1 = 3'b000;
      chk("zero_freq", freq1, 0);
      chk("zero_done", done1, 3'b010);
      chk("zero_busy", busy1, 0);
      chk("zero_active", active1, 3);
      tick();
      chk("zero_done_once", done1, 0);

      // Timed rest.
      set_req(1, 0, 2); valid1 = 3'b010;
      tick(); valid1 = 3'b000;
      for (int c = 0; c < 8; c++) begin
         chk("rest_freq", freq1, 0);
         chk("rest_busy", busy1, 1);
         chk("rest_no_done", done1, 0);
         tick();
      end
      chk("rest_done", done1, 3'b010);
      for (int c = 0; c < 8; c++) tick();
      chk("rest_idle", busy1, 0);

      // Reset in the middle of a note.
      set_req(2, 784, 5); valid1 = 3'b100;
      tick(); valid1 = 3'b000;
      tick(); tick(); tick();
      chk("rstmid_playing", freq1, 784);
      rst = 1'b1;
      tick();
      chk("rstmid_freq", freq1, 0);
      chk("rstmid_active", active1, 3);
      chk("rstmid_busy", busy1, 0);
      chk("rstmid_done", done1, 0);
      chk("rstmid_aborted", ab1, 0);
      rst = 1'b0;
      tick();
      chk("rstmid_quiet", done1 | ab1, 0);
      set_req(1, 262, 1); valid1 = 3'b010;
      #1 chk("rstmid_ready", ready1, 3'b010);
      tick(); valid1 = 3'b000;
      chk("rstmid_new_freq", freq1, 262);
      chk("rstmid_new_active", active1, 1);
      for (int c = 0; c < 12; c++) tick();

      // Random traffic on dut1 against the note-level model.
      rst = 1'b1; valid1 = 3'b000; valid0 = 3'b000;
      tick();
      rst = 1'b0;
      m_own = -1; m_freq = 0; m_play = 0; m_gap = 0; m_t = 1;
      m_done = 3'b000; m_ab = 3'b000; m_ready = 3'b000;
      for (int c = 0; c < 2500; c++) begin
         @(negedge clk);
         model_ready();
         chk("rnd_ready", ready1, m_ready);
         @(posedge clk);
         model_step();
         #1;
         chk("rnd_freq", freq1, m_freq);
         chk("rnd_done", done1, m_done);
         chk("rnd_aborted", ab1, m_ab);
         chk("rnd_active", active1, (m_own < 0) ? 3 : m_own);
         chk("rnd_busy", busy1, (m_play > 0 || m_gap > 0) ? 1 : 0);
         for (int i = 0; i < 3; i++) begin
            if (m_ready[i]) begin
               valid1[i] = 1'b0;
            end else if (valid1[i]) begin
               if ($urandom_range(0, 31) == 0) valid1[i] = 1'b0;
            end else if ($urandom_range(0, 4) == 0) begin
               set_req(i, ($urandom_range(0, 3) == 0) ? 10'd0 : 10'($urandom_range(1, 1023)),
                       10'($urandom_range(0, 4)));
               valid1[i] = 1'b1;
            end
         end
         tpm = 16'($urandom_range(0, 3));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/tone_arbiter.md
# tone_arbiter

Three-requester scheduler that owns the single square-wave tone generator in the game datapath. Each requester (game tones, jingle sequencer, UI feedback) submits a note as a (frequency, duration-in-ms) pair. The arbiter grants the generator by fixed priority, times the note in milliseconds from `ticks_per_milli`, inserts a silent gap between notes, and optionally preempts a lower-priority note. Its registered `freq` output drives the tone generator's frequency input directly.

## Interface
Parameters:
- GAP_MS, default 20: silent gap after each completed note, in ms (0 = no gap).
- PREEMPT, default 1: 1 = a higher-priority request aborts the current note; 0 = the current note always runs to completion.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- ticks_per_milli  in  16  clk cycles per ms; 0 is treated as 1
- req_valid  in  3  per-requester note valid; index 0 has highest priority
- req_freq  in  30  {r2,r1,r0}, 10 b each, Hz; 0 = rest (silent but timed)
- req_ms  in  30  {r2,r1,r0}, 10 b each, duration in ms
- req_ready  out  3  one-hot grant, combinational; a note is accepted at the edge where req_valid[i] & req_ready[i]
- freq  out  10  registered, current tone frequency to the tone generator
- note_done  out  3  one-cycle pulse, note completed normally
- note_aborted  out  3  one-cycle pulse, note preempted
- active  out  2  current owner index; 3 = none
- busy  out  1  high in PLAY or GAP

## Operation
- States: IDLE, PLAY, GAP.
- IDLE:
  - freq = 0.
  - req_ready = one-hot of the lowest-index asserted req_valid.
  - On accept: latch freq, ms, owner and T = max(ticks_per_milli, 1); clear the tick and ms counters.
  - If req_ms ≠ 0: go to PLAY and set freq to the latched frequency.
  - If req_ms = 0: stay in IDLE, keep freq = 0, and pulse note_done[owner] in the next cycle.
- PLAY:
  - The tick counter runs 0..T-1; the ms counter increments on wrap.
  - When the ms counter reaches the latched duration: freq ← 0, pulse note_done[owner], active ← 3, then go to GAP (or to IDLE if GAP_MS = 0).
  - Preemption (PREEMPT = 1 only): req_ready is the one-hot of the lowest asserted index below owner. On accept: pulse note_aborted[old owner], latch the new note, restart the counters and load freq. No gap is inserted.
  - If the preempting note has ms = 0: pulse note_aborted[old] and note_done[new] together, then go to IDLE with freq = 0.
- GAP:
  - freq = 0, req_ready = 0 (no preemption).
  - After GAP_MS ms, go to IDLE.
- Requesters must hold req_valid, req_freq and req_ms stable until accepted. Dropping req_valid before acceptance is legal and has no effect.
- ticks_per_milli is sampled only at accept; changes mid-note have no effect.
- Arithmetic: tick counter 16 b, ms counter 10 b, no overflow possible. Maximum note length 1023 ms.

## Timing
- Reset values: freq = 0, req_ready = 0 (state IDLE, no valid), note_done = 0, note_aborted = 0, active = 3, busy = 0. All counters are 0.
- Reset mid-note: silence in the next cycle; no done or aborted pulse.
- Accept at edge N: freq, active and busy take their new values at N+1.
- freq stays nonzero (for a nonzero note) for exactly req_ms·T cycles.
- The note_done pulse coincides with the first cycle of freq = 0.
- GAP lasts GAP_MS·T cycles. req_ready can assert in the first IDLE cycle after GAP, so the next note starts GAP_MS·T + 1 cycles after done.
- Preemption: the new freq appears at the cycle after the accept edge; the note_aborted pulse appears in that same cycle.
- note_done and a new accept for the same requester never occur in the same cycle.
- Simultaneous requests: the lowest index wins. Others wait, because the winner holds the generator until done.

## Test plan
All scenarios use T = 4, GAP_MS = 2.
- Single note: r1 requests 262 Hz for 3 ms → req_ready[1] asserts the same cycle; freq = 262 for 12 cycles; note_done[1] pulses; freq = 0 and busy = 1 for 8 cycles; then busy = 0 and active = 3.
- Priority: r0 (196 Hz, 2 ms) and r2 (784 Hz, 2 ms) are valid in the same cycle → r0 is granted. freq = 196 for 8 cycles, then 8-cycle gap, then r2 is granted and freq = 784 for 8 cycles.
- Preemption, PREEMPT = 1: r2 plays 784 Hz for 10 ms; r0 requests 196 Hz, 1 ms, at cycle 12 of the note → note_aborted[2] pulses, freq = 196 the next cycle for 4 cycles, then note_done[0]. No done pulse for r2.
- No preemption, PREEMPT = 0: same stimulus → r2 completes all 40 cycles, then the gap, then r0 plays 196.
- Zero and rest notes:
  - r1 with ms = 0 → freq stays 0 and note_done[1] pulses the next cycle.
  - r1 with freq = 0, ms = 2 → freq = 0, busy = 1 for 8 cycles, then note_done[1].
- Reset mid-note: assert rst during a 784 Hz note → the next cycle has freq = 0, active = 3, busy = 0, and no done or aborted pulse. After rst deasserts, a new request is accepted normally.
